// File: rtl/settings_pkg.sv
// Shared types for the settings controller: FSM states, edit-field indices
// and a width helper.
package settings_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FLD_MODE  = 2'd0,
      FLD_DIFF  = 2'd1,
      FLD_SPEED = 2'd2
   } field_e;

   localparam int NUM_FIELDS = 3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/settings_field_cnt.sv
// One shadow field: loadable up/down counter that stays within 0..N-1,
// wrapping at both ends by explicit compare rather than 2**W overflow.
module settings_field_cnt #(
   parameter int W   = 2,
   parameter int N   = 2,
   parameter int DEF = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] MAX_V = W'(N - 1);
   localparam logic [W-1:0] DEF_V = W'(DEF);

   // inc and dec together cancel and leave the value untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= DEF_V;
      end else if (load) begin
         value <= load_val;
      end else if (inc && !dec) begin
         value <= (value == MAX_V) ? '0 : value + W'(1);
      end else if (dec && !inc) begin
         value <= (value == '0) ? MAX_V : value - W'(1);
      end
   end

endmodule

// File: rtl/settings_ctrl.sv
// Settings controller: active game configuration plus a shadow edit session
// with atomic commit. Optional idle timeout: define SETTINGS_TIMEOUT_EN.
module settings_ctrl
   import settings_pkg::*;
#(
   parameter int MODE_W      = 2,
   parameter int DIFF_W      = 3,
   parameter int SPEED_W     = 2,
   parameter int N_MODES     = 2,
   parameter int N_DIFF      = 3,
   parameter int N_SPEED     = 2,
   parameter int DEF_MODE    = 0,
   parameter int DEF_DIFF    = 0,
   parameter int DEF_SPEED   = 0,
   parameter int TIMEOUT_CYC = 1000000,
   localparam int VAL_W      = max3(MODE_W, DIFF_W, SPEED_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_edit,
   input  logic               btn_sel,
   input  logic               btn_inc,
   input  logic               btn_dec,
   input  logic               btn_ok,
   input  logic               game_active,
   output logic [MODE_W-1:0]  cfg_mode,
   output logic [DIFF_W-1:0]  cfg_difficulty,
   output logic [SPEED_W-1:0] cfg_speed,
   output logic               cfg_update,
   output logic               edit_active,
   output logic [1:0]         edit_field,
   output logic [VAL_W-1:0]   edit_val
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_EDIT   = EDIT;
   localparam logic [1:0] ST_COMMIT = COMMIT;

   logic [1:0]            state;
   logic [1:0]            field_q;
   logic [MODE_W-1:0]     sh_mode;
   logic [DIFF_W-1:0]     sh_diff;
   logic [SPEED_W-1:0]    sh_speed;
   logic [NUM_FIELDS-1:0] inc_f;
   logic [NUM_FIELDS-1:0] dec_f;
   logic                  enter;
   logic                  in_edit;
   logic                  adj;
   logic                  timeout_hit;

   assign enter   = (state == ST_IDLE) && btn_edit && !game_active;
   assign in_edit = (state == ST_EDIT);
   // value edits only happen when nothing of higher priority claims the cycle
   assign adj     = in_edit && !game_active && !btn_ok && !btn_sel;

   assign inc_f[0] = adj && btn_inc && (field_q == FLD_MODE);
   assign inc_f[1] = adj && btn_inc && (field_q == FLD_DIFF);
   assign inc_f[2] = adj && btn_inc && (field_q == FLD_SPEED);
   assign dec_f[0] = adj && btn_dec && (field_q == FLD_MODE);
   assign dec_f[1] = adj && btn_dec && (field_q == FLD_DIFF);
   assign dec_f[2] = adj && btn_dec && (field_q == FLD_SPEED);

`ifdef SETTINGS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] idle_cnt;
   logic             any_btn;

   assign any_btn     = btn_edit | btn_sel | btn_inc | btn_dec | btn_ok;
   assign timeout_hit = in_edit && !any_btn && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (enter || any_btn) begin
         idle_cnt <= '0;
      end else if (in_edit) begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end
`else
   // TIMEOUT_CYC has no effect in this build; the term folds to 0
   assign timeout_hit = (TIMEOUT_CYC == 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (enter) state <= ST_EDIT;
            ST_EDIT: begin
               if (game_active || timeout_hit) state <= ST_IDLE;
               else if (btn_ok)                state <= ST_COMMIT;
            end
            ST_COMMIT: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         field_q <= 2'd0;
      end else if (enter) begin
         field_q <= 2'd0;
      end else if (in_edit && !game_active && !btn_ok && btn_sel) begin
         field_q <= (field_q == 2'(NUM_FIELDS - 1)) ? 2'd0 : field_q + 2'd1;
      end
   end

   // all three fields move to active together on the COMMIT exit edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_mode       <= MODE_W'(DEF_MODE);
         cfg_difficulty <= DIFF_W'(DEF_DIFF);
         cfg_speed      <= SPEED_W'(DEF_SPEED);
         cfg_update     <= 1'b0;
      end else if (state == ST_COMMIT) begin
         cfg_mode       <= sh_mode;
         cfg_difficulty <= sh_diff;
         cfg_speed      <= sh_speed;
         cfg_update     <= 1'b1;
      end else begin
         cfg_update     <= 1'b0;
      end
   end

   settings_field_cnt #(.W(MODE_W), .N(N_MODES), .DEF(DEF_MODE)) u_mode (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (enter),
      .load_val (cfg_mode),
      .inc      (inc_f[0]),
      .dec      (dec_f[0]),
      .value    (sh_mode)
   );

   settings_field_cnt #(.W(DIFF_W), .N(N_DIFF), .DEF(DEF_DIFF)) u_diff (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (enter),
      .load_val (cfg_difficulty),
      .inc      (inc_f[1]),
      .dec      (dec_f[1]),
      .value    (sh_diff)
   );

   settings_field_cnt #(.W(SPEED_W), .N(N_SPEED), .DEF(DEF_SPEED)) u_speed (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (enter),
      .load_val (cfg_speed),
      .inc      (inc_f[2]),
      .dec      (dec_f[2]),
      .value    (sh_speed)
   );

   assign edit_active = in_edit;
   assign edit_field  = field_q;

   always_comb begin
      edit_val = '0;
      case (field_q)
         FLD_MODE:  edit_val = VAL_W'(sh_mode);
         FLD_DIFF:  edit_val = VAL_W'(sh_diff);
         FLD_SPEED: edit_val = VAL_W'(sh_speed);
         default:   edit_val = '0;
      endcase
   end

endmodule

// File: tb/tb_settings_ctrl.sv
// Bench for settings_ctrl: directed scenarios plus random button traffic,
// checked cycle by cycle against a modular-arithmetic reference model.
module tb_settings_ctrl;

   localparam int MODE_W = 2, DIFF_W = 3, SPEED_W = 2;
   localparam int N_MODES = 2, N_DIFF = 3, N_SPEED = 2;
   localparam int DEF_MODE = 0, DEF_DIFF = 2, DEF_SPEED = 0;
   localparam int TIMEOUT_CYC = 16;
   localparam int VAL_W = 3;
   localparam int M_IDLE = 0, M_EDIT = 1, M_COMMIT = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               btn_edit, btn_sel, btn_inc, btn_dec, btn_ok, game_active;
   logic [MODE_W-1:0]  cfg_mode;
   logic [DIFF_W-1:0]  cfg_difficulty;
   logic [SPEED_W-1:0] cfg_speed;
   logic               cfg_update;
   logic               edit_active;
   logic [1:0]         edit_field;
   logic [VAL_W-1:0]   edit_val;

   always #5 clk = ~clk;

   settings_ctrl #(
      .MODE_W(MODE_W), .DIFF_W(DIFF_W), .SPEED_W(SPEED_W),
      .N_MODES(N_MODES), .N_DIFF(N_DIFF), .N_SPEED(N_SPEED),
      .DEF_MODE(DEF_MODE), .DEF_DIFF(DEF_DIFF), .DEF_SPEED(DEF_SPEED),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_edit(btn_edit), .btn_sel(btn_sel), .btn_inc(btn_inc),
      .btn_dec(btn_dec), .btn_ok(btn_ok), .game_active(game_active),
      .cfg_mode(cfg_mode), .cfg_difficulty(cfg_difficulty), .cfg_speed(cfg_speed),
      .cfg_update(cfg_update), .edit_active(edit_active),
      .edit_field(edit_field), .edit_val(edit_val)
   );

   typedef struct packed {
      logic               act;
      logic [1:0]         fld;
      logic [VAL_W-1:0]   val;
      logic [MODE_W-1:0]  mode;
      logic [DIFF_W-1:0]  diff;
      logic [SPEED_W-1:0] speed;
      logic               upd;
   } stat_t;

   int         tests = 0;
   int         fails = 0;
   logic [6:0] exp_q[$];
   stat_t      stat_q[$];
   bit         mon_en = 1'b0;

   int m_act[3], m_sh[3], m_fld, m_st, m_idle;
   int m_n[3] = '{N_MODES, N_DIFF, N_SPEED};
   bit m_upd;
   bit ga;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_act[0] = DEF_MODE; m_act[1] = DEF_DIFF; m_act[2] = DEF_SPEED;
      for (int k = 0; k < 3; k++) m_sh[k] = m_act[k];
      m_fld = 0; m_st = M_IDLE; m_idle = 0; m_upd = 1'b0;
   endtask

   // What the settings should look like after the coming clock edge.
   task automatic model_step(input bit e, input bit s, input bit i, input bit d,
                             input bit o, input bit g);
      bit any, tmo;
      any = e | s | i | d | o;
      tmo = 1'b0;
      m_upd = 1'b0;
      case (m_st)
         M_IDLE: begin
            if (e && !g) begin
               for (int k = 0; k < 3; k++) m_sh[k] = m_act[k];
               m_fld = 0; m_idle = 0; m_st = M_EDIT;
            end
         end
         M_EDIT: begin
`ifdef SETTINGS_TIMEOUT_EN
            tmo = !any && (m_idle == TIMEOUT_CYC - 1);
`endif
            m_idle = any ? 0 : m_idle + 1;
            if (g)                m_st = M_IDLE;
            else if (o)           m_st = M_COMMIT;
            else if (tmo)         m_st = M_IDLE;
            else if (s)           m_fld = (m_fld + 1) % 3;
            else if (i && !d)     m_sh[m_fld] = (m_sh[m_fld] + 1) % m_n[m_fld];
            else if (d && !i)     m_sh[m_fld] = (m_sh[m_fld] + m_n[m_fld] - 1) % m_n[m_fld];
         end
         default: begin
            for (int k = 0; k < 3; k++) m_act[k] = m_sh[k];
            m_upd = 1'b1;
            m_st = M_IDLE;
            exp_q.push_back({MODE_W'(m_act[0]), DIFF_W'(m_act[1]), SPEED_W'(m_act[2])});
         end
      endcase
   endtask

   task automatic cyc(input bit e, input bit s, input bit i, input bit d,
                      input bit o, input bit g);
      stat_t x;
      @(negedge clk);
      btn_edit = e; btn_sel = s; btn_inc = i; btn_dec = d; btn_ok = o; game_active = g;
      model_step(e, s, i, d, o, g);
      x.act   = (m_st == M_EDIT);
      x.fld   = 2'(m_fld);
      x.val   = VAL_W'(m_sh[m_fld]);
      x.mode  = MODE_W'(m_act[0]);
      x.diff  = DIFF_W'(m_act[1]);
      x.speed = SPEED_W'(m_act[2]);
      x.upd   = m_upd;
      if (mon_en) stat_q.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en && stat_q.size() > 0) begin
         stat_t x;
         x = stat_q.pop_front();
         check("edit_active", int'(edit_active), int'(x.act));
         check("edit_field", int'(edit_field), int'(x.fld));
         check("edit_val", int'(edit_val), int'(x.val));
         check("cfg_mode", int'(cfg_mode), int'(x.mode));
         check("cfg_difficulty", int'(cfg_difficulty), int'(x.diff));
         check("cfg_speed", int'(cfg_speed), int'(x.speed));
         check("cfg_update", int'(cfg_update), int'(x.upd));
      end
      if (mon_en && cfg_update) begin
         if (exp_q.size() == 0) begin
            check("spurious_update", 1, 0);
         end else begin
            logic [6:0] c;
            c = exp_q.pop_front();
            check("commit_cfg", int'({cfg_mode, cfg_difficulty, cfg_speed}), int'(c));
         end
      end
   end

   initial begin
      int r;
      bit e, s, i, d, o;
      rst_n = 1'b1;
      btn_edit = 0; btn_sel = 0; btn_inc = 0; btn_dec = 0; btn_ok = 0; game_active = 0;
      ga = 1'b0;
      model_reset();
      #1 rst_n = 1'b0;
      #11;
      check("rst_cfg_mode", int'(cfg_mode), DEF_MODE);
      check("rst_cfg_difficulty", int'(cfg_difficulty), DEF_DIFF);
      check("rst_cfg_speed", int'(cfg_speed), DEF_SPEED);
      check("rst_cfg_update", int'(cfg_update), 0);
      check("rst_edit_active", int'(edit_active), 0);
      check("rst_edit_field", int'(edit_field), 0);
      #10 rst_n = 1'b1;
      mon_en = 1'b1;

      // difficulty 2 -> 0, then edit/sel/inc/inc/ok -> 2
      cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0); cyc(0,0,0,0,1,0); idle(3);
      cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0); cyc(0,0,1,0,0,0);
      cyc(0,0,0,0,1,0); idle(3);
      // wrap: diff 2 inc -> 0, speed 0 dec -> 1, inc+dec hold, commit
      cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0); cyc(0,1,0,0,0,0);
      cyc(0,0,0,1,0,0); cyc(0,0,1,1,0,0); cyc(0,0,0,0,1,0); idle(3);
      // lockout: edit ignored while running; game start mid-edit discards
      cyc(1,0,0,0,0,1); cyc(0,0,0,0,0,1); cyc(0,0,0,0,1,0); idle(1);
      cyc(1,0,0,0,0,0); cyc(0,0,1,0,0,0); cyc(0,0,0,0,1,1); cyc(0,0,0,0,0,1); idle(3);
      // ok with inc: commit pre-increment shadow
      cyc(1,0,0,0,0,0); cyc(0,0,1,0,0,0); cyc(0,0,1,0,1,0); idle(3);
`ifdef SETTINGS_TIMEOUT_EN
      cyc(1,0,0,0,0,0); idle(20);
      cyc(1,0,0,0,0,0); idle(9); cyc(0,0,1,0,0,0); idle(20);
`endif

      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 19) == 0) ga = !ga;
         e = (r == 0);
         s = (r == 1);
         i = (r == 2) || (r == 3) || (r == 5) || (r == 7);
         d = (r == 4) || (r == 5);
         o = (r == 6) || (r == 7);
         cyc(e, s, i, d, o, ga);
      end
      cyc(0,0,0,0,0,1); idle(3);

      // async reset in the middle of an edit session
      cyc(1,0,0,0,0,0); cyc(0,0,1,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,0,1,0,0);
      cyc(0,1,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0); idle(1);
      @(posedge clk);
      #2 mon_en = 1'b0;
      check("pre_rst_in_edit", int'(edit_active), 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_cfg_mode", int'(cfg_mode), DEF_MODE);
      check("arst_cfg_difficulty", int'(cfg_difficulty), DEF_DIFF);
      check("arst_cfg_speed", int'(cfg_speed), DEF_SPEED);
      check("arst_cfg_update", int'(cfg_update), 0);
      check("arst_edit_active", int'(edit_active), 0);
      check("arst_edit_field", int'(edit_field), 0);
      check("arst_edit_val", int'(edit_val), DEF_MODE);
      check("drain_before_rst", exp_q.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      stat_q.delete();
      exp_q.delete();
      mon_en = 1'b1;
      cyc(0,0,0,0,1,0); idle(2);
      cyc(1,0,0,0,0,0); cyc(0,0,0,0,1,0); idle(3);

      @(posedge clk);
      #2;
      check("commit_queue_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
